// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types and widths for the FFT stage sequencer
package fft_seq_pkg;
  localparam int STRIDE_W = 10;
  localparam int STAGE_W = 4;
  localparam int LANES = 4;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, FINISH} state_e;
  // log2 of points per group (2 points per butterfly lane)
  function automatic int grp_log2(input int lanes);
    return $clog2(2 * lanes);
  endfunction
  // group index width for a transform of 2^log2n points
  function automatic int addr_w(input int log2n, input int lanes);
    return log2n - grp_log2(lanes);
  endfunction
endpackage

// File: rtl/fft_seq_delay_line.sv
// fft_seq_delay_line: fixed-depth valid/address pipeline matching the butterfly latency
// Ports: clk, resetn (async active-low); i_VLD/i_ADDR in; o_VLD/o_ADDR after p_DEPTH cycles;
// o_ANY_NEXT is high when any entry will be valid after the coming edge.
module fft_seq_delay_line #(
  parameter int p_DEPTH = 4,
  parameter int p_AW = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_VLD,
  input  logic [p_AW-1:0] i_ADDR,
  output logic            o_VLD,
  output logic [p_AW-1:0] o_ADDR,
  output logic            o_ANY_NEXT
);
  logic [p_DEPTH-1:0] vld_q, vld_d;
  logic [p_DEPTH-1:0][p_AW-1:0] addr_q, addr_d;
  assign vld_d = (vld_q << 1) | p_DEPTH'(i_VLD);
  assign addr_d = (addr_q << p_AW) | (p_DEPTH * p_AW)'(i_ADDR);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      vld_q <= '0;
      addr_q <= '0;
    end else begin
      vld_q <= vld_d;
      addr_q <= addr_d;
    end
  assign o_VLD = vld_q[p_DEPTH-1];
  assign o_ADDR = addr_q[p_DEPTH-1];
  assign o_ANY_NEXT = |vld_d;
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: sequences group reads/writes across the stages of an in-place FFT
// Ports: clk, resetn (async active-low); i_START pulse with i_NUM_STAGES; i_STALL holds issue;
// o_STRIDE/o_STAGE current stage; o_RD_EN/o_RD_ADDR group reads; o_WR_EN/o_WR_ADDR delayed writes;
// o_BUSY level, o_DONE pulse; o_CYCLE_COUNT busy-cycle counter, present only with FFT_SEQ_PERF_CNT_EN.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int p_LOG2N = 10,
  parameter int p_BF_LATENCY = 3,
  parameter int p_LANES = LANES
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  i_START,
  input  logic [STAGE_W-1:0]                    i_NUM_STAGES,
  input  logic                                  i_STALL,
  output logic [STRIDE_W-1:0]                   o_STRIDE,
  output logic [STAGE_W-1:0]                    o_STAGE,
  output logic                                  o_RD_EN,
  output logic [addr_w(p_LOG2N, p_LANES)-1:0]   o_RD_ADDR,
  output logic                                  o_WR_EN,
  output logic [addr_w(p_LOG2N, p_LANES)-1:0]   o_WR_ADDR,
  output logic                                  o_BUSY,
  output logic                                  o_DONE,
  output logic [31:0]                           o_CYCLE_COUNT
);
  localparam int AW = addr_w(p_LOG2N, p_LANES);
  localparam logic [STAGE_W-1:0] MAXS = STAGE_W'(p_LOG2N);
  localparam logic [STAGE_W-1:0] LGS = STAGE_W'(grp_log2(p_LANES));
  state_e state_q, state_d;
  logic [STAGE_W-1:0] s_q, s_d, stage_q, stage_d, s_cl, s_new;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [AW-1:0] addr_q, addr_d, g_last;
  logic rd_en, any_d;
  // fewer stages than one group spans means nothing to do
  assign s_cl = i_NUM_STAGES > MAXS ? MAXS : i_NUM_STAGES;
  assign s_new = s_cl < LGS ? '0 : s_cl;
  assign g_last = AW'((32'd1 << (s_q - LGS)) - 32'd1);
  assign rd_en = state_q == ISSUE && !i_STALL;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    stage_d = stage_q;
    stride_d = stride_q;
    addr_d = addr_q;
    case (state_q)
      IDLE: if (i_START) begin
        s_d = s_new;
        stage_d = '0;
        addr_d = '0;
        stride_d = s_new == '0 ? '0 : STRIDE_W'(32'd1 << (s_new - 4'd1));
        state_d = s_new == '0 ? FINISH : ISSUE;
      end
      ISSUE: if (rd_en) begin
        addr_d = addr_q == g_last ? '0 : addr_q + 1'b1;
        state_d = addr_q == g_last ? DRAIN : ISSUE;
      end
      // no new reads here, so an empty pipeline after this edge means the last write is now
      DRAIN: state_d = any_d ? DRAIN : NEXT;
      NEXT: if (stage_q == s_q - 4'd1) state_d = FINISH;
      else begin
        state_d = ISSUE;
        stage_d = stage_q + 1'b1;
        stride_d = stride_q >> 1;
      end
      FINISH: begin
        state_d = IDLE;
        s_d = '0;
        stage_d = '0;
        stride_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      s_q <= '0;
      stage_q <= '0;
      stride_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      stage_q <= stage_d;
      stride_q <= stride_d;
      addr_q <= addr_d;
    end
  fft_seq_delay_line #(.p_DEPTH(p_BF_LATENCY + 1), .p_AW(AW)) u_dly (
    .clk(clk),
    .resetn(resetn),
    .i_VLD(rd_en),
    .i_ADDR(addr_q),
    .o_VLD(o_WR_EN),
    .o_ADDR(o_WR_ADDR),
    .o_ANY_NEXT(any_d)
  );
  assign o_RD_EN = rd_en;
  assign o_RD_ADDR = addr_q;
  assign o_STRIDE = stride_q;
  assign o_STAGE = stage_q;
  assign o_BUSY = state_q != IDLE;
  assign o_DONE = state_q == FINISH;
`ifdef FFT_SEQ_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == IDLE && i_START) ? '0 :
                 (o_BUSY && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_CYCLE_COUNT = cnt_q;
`else
  assign o_CYCLE_COUNT = '0;
`endif
endmodule
